// File: rtl/request_node_pkg.sv
// Shared types and helpers for the requester-side interconnect node.
// State encodings, default widths and the address-to-CN decode helper.
package request_node_pkg;

    typedef enum logic [2:0] {
        RN_IDLE   = 3'd0,
        RN_REQ    = 3'd1,
        RN_SETUP  = 3'd2,
        RN_ACCESS = 3'd3,
        RN_DONE   = 3'd4
    } rn_state_t;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 64;

    // Target code 3 has no CN behind it.
    localparam logic [1:0] TGT_ERR = 2'd3;

    function automatic logic [2:0] tgt_onehot(input logic [1:0] tgt);
        logic [2:0] oh;
        case (tgt)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/request_node_flit_codec.sv
// Combinational packing of request flits and selection/unpacking of the
// targeted CN's response flit; field order matches complete_node.
module rn_flit_codec
    import request_node_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REQ_FLIT_WIDTH = ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH/8 + 8,
    parameter int RSP_FLIT_WIDTH = DATA_WIDTH + 2
) (
    input  logic [ADDR_WIDTH-1:0]     paddr,
    input  logic [2:0]                pprot,
    input  logic                      pnse,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic                      pwakeup,
    output logic [REQ_FLIT_WIDTH-1:0] txreq,
    input  logic [1:0]                tgt,
    input  logic [RSP_FLIT_WIDTH-1:0] rxrsp_1,
    input  logic [RSP_FLIT_WIDTH-1:0] rxrsp_2,
    input  logic [RSP_FLIT_WIDTH-1:0] rxrsp_3,
    output logic                      rsp_pready,
    output logic [DATA_WIDTH-1:0]     rsp_prdata,
    output logic                      rsp_pslverr
);

    logic [RSP_FLIT_WIDTH-1:0] rsp_sel;

    assign txreq = {paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb, pwakeup};

    always_comb begin
        rsp_sel = '0;
        case (tgt)
            2'd0:    rsp_sel = rxrsp_1;
            2'd1:    rsp_sel = rxrsp_2;
            2'd2:    rsp_sel = rxrsp_3;
            default: rsp_sel = '0;
        endcase
    end

    assign rsp_pready  = rsp_sel[RSP_FLIT_WIDTH-1];
    assign rsp_prdata  = rsp_sel[DATA_WIDTH:1];
    assign rsp_pslverr = rsp_sel[0];

endmodule

// File: rtl/request_node.sv
// Requester node: takes one APB transfer, hands it to the decoded CN over the
// rn_valid/cn_ready handshake and ICN flits, and returns the CN's completion.
//
// state  | meaning
// IDLE   | waiting for an APB setup cycle; latches request and target
// REQ    | rn_valid raised, waiting for cn_ready (bounded by TIMEOUT)
// SETUP  | flit carries psel=1, penable=0
// ACCESS | flit carries psel=1, penable=1; waiting for targeted CN's pready
// DONE   | one-cycle s_pready with captured data/error
module request_node
    import request_node_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REQ_FLIT_WIDTH = ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH/8 + 8,
    parameter int RSP_FLIT_WIDTH = DATA_WIDTH + 2,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [ADDR_WIDTH-1:0]     s_paddr,
    input  logic [2:0]                s_pprot,
    input  logic                      s_pnse,
    input  logic                      s_psel,
    input  logic                      s_penable,
    input  logic                      s_pwrite,
    input  logic [DATA_WIDTH-1:0]     s_pwdata,
    input  logic [DATA_WIDTH/8-1:0]   s_pstrb,
    input  logic                      s_pwakeup,
    output logic                      s_pready,
    output logic [DATA_WIDTH-1:0]     s_prdata,
    output logic                      s_pslverr,
    output logic [2:0]                rn_valid,
    input  logic [2:0]                cn_ready,
    output logic [REQ_FLIT_WIDTH-1:0] icn_txreq,
    input  logic [RSP_FLIT_WIDTH-1:0] icn_rxrsp_1,
    input  logic [RSP_FLIT_WIDTH-1:0] icn_rxrsp_2,
    input  logic [RSP_FLIT_WIDTH-1:0] icn_rxrsp_3
);

    localparam int             TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

    rn_state_t                 state;
    logic [TW-1:0]             to_cnt;
    logic [1:0]                tgt;
    logic [ADDR_WIDTH-1:0]     r_paddr;
    logic [2:0]                r_pprot;
    logic                      r_pnse;
    logic                      r_pwrite;
    logic [DATA_WIDTH-1:0]     r_pwdata;
    logic [DATA_WIDTH/8-1:0]   r_pstrb;
    logic                      r_pwakeup;
    logic                      f_psel;
    logic                      f_penable;
    logic                      rsp_pready;
    logic [DATA_WIDTH-1:0]     rsp_prdata;
    logic                      rsp_pslverr;
    logic [1:0]                dec_tgt;

    assign dec_tgt = s_paddr[ADDR_WIDTH-1 -: 2];

    rn_flit_codec #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .REQ_FLIT_WIDTH (REQ_FLIT_WIDTH),
        .RSP_FLIT_WIDTH (RSP_FLIT_WIDTH)
    ) u_codec (
        .paddr       (r_paddr),
        .pprot       (r_pprot),
        .pnse        (r_pnse),
        .psel        (f_psel),
        .penable     (f_penable),
        .pwrite      (r_pwrite),
        .pwdata      (r_pwdata),
        .pstrb       (r_pstrb),
        .pwakeup     (r_pwakeup),
        .txreq       (icn_txreq),
        .tgt         (tgt),
        .rxrsp_1     (icn_rxrsp_1),
        .rxrsp_2     (icn_rxrsp_2),
        .rxrsp_3     (icn_rxrsp_3),
        .rsp_pready  (rsp_pready),
        .rsp_prdata  (rsp_prdata),
        .rsp_pslverr (rsp_pslverr)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state     <= RN_IDLE;
            to_cnt    <= '0;
            tgt       <= '0;
            r_paddr   <= '0;
            r_pprot   <= '0;
            r_pnse    <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pwakeup <= 1'b0;
            f_psel    <= 1'b0;
            f_penable <= 1'b0;
            rn_valid  <= '0;
            s_pready  <= 1'b0;
            s_prdata  <= '0;
            s_pslverr <= 1'b0;
        end else begin
            // Completion outputs are single-cycle; only the DONE entry sets them.
            s_pready  <= 1'b0;
            s_prdata  <= '0;
            s_pslverr <= 1'b0;
            case (state)
                RN_IDLE: begin
                    if (s_psel && !s_penable) begin
                        r_paddr   <= s_paddr;
                        r_pprot   <= s_pprot;
                        r_pnse    <= s_pnse;
                        r_pwrite  <= s_pwrite;
                        r_pwdata  <= s_pwdata;
                        r_pstrb   <= s_pstrb;
                        r_pwakeup <= s_pwakeup;
                        tgt       <= dec_tgt;
                        if (dec_tgt == TGT_ERR) begin
                            state     <= RN_DONE;
                            s_pready  <= 1'b1;
                            s_pslverr <= 1'b1;
                        end else begin
                            state    <= RN_REQ;
                            rn_valid <= tgt_onehot(dec_tgt);
                            to_cnt   <= '0;
                        end
                    end
                end
                RN_REQ: begin
                    // rn_valid is one-hot on the target, so this masks off other CNs.
                    if ((cn_ready & rn_valid) != 3'b000) begin
                        state  <= RN_SETUP;
                        f_psel <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state     <= RN_DONE;
                        rn_valid  <= '0;
                        s_pready  <= 1'b1;
                        s_pslverr <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RN_SETUP: begin
                    state     <= RN_ACCESS;
                    f_penable <= 1'b1;
                end
                RN_ACCESS: begin
                    if (rsp_pready) begin
                        state     <= RN_DONE;
                        rn_valid  <= '0;
                        f_psel    <= 1'b0;
                        f_penable <= 1'b0;
                        s_pready  <= 1'b1;
                        s_prdata  <= rsp_prdata;
                        s_pslverr <= rsp_pslverr;
                    end
                end
                RN_DONE: begin
                    state <= RN_IDLE;
                end
                default: begin
                    state     <= RN_IDLE;
                    rn_valid  <= '0;
                    f_psel    <= 1'b0;
                    f_penable <= 1'b0;
                end
            endcase
        end
    end

endmodule
